// File: rtl/data_memory_if.sv
// Request/response bundle for the data memory: valid/ready request side, pulsed response side.
interface data_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [15:0]       misalign_cnt;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, misalign_cnt
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, misalign_cnt
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory; misaligned words are split into two row beats.
// NB = DATA_W/8 is taken to be a power of two so row/lane are plain address slices.
module data_memory_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    data_memory_if.slave bus
);
    localparam int NB   = DATA_W / 8;
    localparam int LW   = $clog2(NB);
    localparam int RW   = ADDR_W - LW;
    localparam int ROWS = 2 ** RW;

    typedef enum logic {IDLE, BEAT2} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [ROWS] = '{default: '0};

    logic              lat_we;
    logic [RW-1:0]     lat_row;
    logic [LW-1:0]     lat_lane;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] hold;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [15:0]       misalign_cnt;

    logic              ready;
    logic              misalign;
    logic              do_write;
    logic [RW-1:0]     row;
    logic [LW-1:0]     lane;
    logic [NB-1:0]     lane_en;
    logic [DATA_W-1:0] wr_row;
    logic [DATA_W-1:0] rd_row;
    logic [DATA_W-1:0] rd_shl;
    logic [DATA_W-1:0] byte_ext;
    logic [LW+2:0]     sh_lo;
    logic [LW+3:0]     sh_hi;

    assign misalign = bus.req_size && (bus.req_addr[LW-1:0] != '0);

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        row       = bus.req_addr[ADDR_W-1 -: RW];
        lane      = bus.req_addr[LW-1:0];
        lane_en   = '0;
        wr_row    = '0;
        do_write  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    do_write = bus.req_we;
                    if (!bus.req_size) begin
                        lane_en[lane] = 1'b1;
                        wr_row        = {NB{bus.req_wdata[7:0]}};
                    end else if (!misalign) begin
                        lane_en = '1;
                        wr_row  = bus.req_wdata;
                    end else begin
                        for (int j = 0; j < NB; j++) lane_en[j] = (LW'(j) >= lane);
                        wr_row    = bus.req_wdata >> {lane, 3'b000};
                        state_nxt = BEAT2;
                    end
                end
            end
            BEAT2: begin
                // Second beat always lands on the following row, wrapping past the last one.
                row      = lat_row + 1'b1;
                lane     = lat_lane;
                do_write = lat_we;
                for (int j = 0; j < NB; j++) lane_en[j] = (LW'(j) < lat_lane);
                wr_row    = lat_wdata << ((LW+4)'(DATA_W) - {1'b0, lat_lane, 3'b000});
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            do_write  = 1'b0;
            state_nxt = IDLE;
        end
    end

    assign sh_lo    = {lane, 3'b000};
    assign sh_hi    = (LW+4)'(DATA_W) - {1'b0, lane, 3'b000};
    assign rd_row   = mem[row];
    assign rd_shl   = rd_row << sh_lo;
    assign byte_ext = {{(DATA_W-8){bus.req_signed & rd_shl[DATA_W-1]}}, rd_shl[DATA_W-1 -: 8]};

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int j = 0; j < NB; j++) begin
                if (lane_en[j]) mem[row][DATA_W-1-8*j -: 8] <= wr_row[DATA_W-1-8*j -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            misalign_cnt <= '0;
            hold         <= '0;
            lat_we       <= 1'b0;
            lat_row      <= '0;
            lat_lane     <= '0;
            lat_wdata    <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (misalign) begin
                            lat_we    <= bus.req_we;
                            lat_row   <= row;
                            lat_lane  <= lane;
                            lat_wdata <= bus.req_wdata;
                            hold      <= rd_shl;
                            if (misalign_cnt != 16'hFFFF) misalign_cnt <= misalign_cnt + 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                            if (bus.req_we)        rsp_rdata <= '0;
                            else if (bus.req_size) rsp_rdata <= rd_row;
                            else                   rsp_rdata <= byte_ext;
                        end
                    end
                end
                BEAT2: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= lat_we ? '0 : (hold | (rd_row >> sh_hi));
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = ready;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_rdata    = rsp_rdata;
    assign bus.misalign_cnt = misalign_cnt;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: byte-array reference model checked every cycle, directed literals, random traffic.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_if #(.DATA_W(16), .ADDR_W(8)) bus ();
    data_memory_if #(.DATA_W(32), .ADDR_W(8)) bus32 ();

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(8)) dut   (.clk(clk), .rst(rst), .bus(bus));
    data_memory_ctrl #(.DATA_W(32), .ADDR_W(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int tests = 0;
    int fails = 0;
    logic check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a flat byte array; a misaligned word commits byte 0 now, byte 1 one edge later.
    logic [7:0]  m [256];
    logic        exp_valid, exp_ready;
    logic [15:0] exp_rdata, exp_cnt;
    logic        pend, pend_we;
    logic [7:0]  pend_addr;
    logic [15:0] pend_wd, pend_rd;

    initial begin
        for (int i = 0; i < 256; i++) m[i] = 8'h00;
        exp_valid = 1'b0; exp_ready = 1'b1; exp_rdata = '0; exp_cnt = '0; pend = 1'b0;
        pend_we = 1'b0; pend_addr = '0; pend_wd = '0; pend_rd = '0;
    end

    always @(posedge clk) begin : model
        logic [7:0]  a;
        logic [15:0] rd;
        logic        mis;
        if (rst) begin
            exp_valid = 1'b0; exp_rdata = '0; exp_ready = 1'b1; exp_cnt = '0; pend = 1'b0;
        end else if (pend) begin
            if (pend_we) m[8'(pend_addr + 8'd1)] = pend_wd[7:0];
            exp_valid = 1'b1;
            exp_rdata = pend_we ? 16'h0 : pend_rd;
            exp_ready = 1'b1;
            pend      = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (bus.req_valid) begin
                a   = bus.req_addr;
                mis = bus.req_size && a[0];
                rd  = '0;
                if (bus.req_we) begin
                    if (!bus.req_size) m[a] = bus.req_wdata[7:0];
                    else begin
                        m[a] = bus.req_wdata[15:8];
                        if (!mis) m[8'(a + 8'd1)] = bus.req_wdata[7:0];
                    end
                end else if (!bus.req_size) begin
                    rd = bus.req_signed ? {{8{m[a][7]}}, m[a]} : {8'h00, m[a]};
                end else begin
                    rd = {m[a], m[8'(a + 8'd1)]};
                end
                if (mis) begin
                    pend = 1'b1; pend_we = bus.req_we; pend_addr = a;
                    pend_wd = bus.req_wdata; pend_rd = rd;
                    exp_ready = 1'b0;
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end else begin
                    exp_valid = 1'b1;
                    exp_rdata = rd;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (check_en) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
            chk("misalign_cnt", 32'(bus.misalign_cnt), 32'(exp_cnt));
        end
    end

    task automatic issue(input logic we, input logic size, input logic sgn,
                         input logic [7:0] addr, input logic [15:0] wd);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        chk("ready wait", 32'(n), 32'd0);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_we = 1'b0;
    endtask

    task automatic rd(input string name, input logic size, input logic sgn,
                      input logic [7:0] addr, input logic [15:0] exp, input int lat);
        int n = 1;
        issue(1'b0, size, sgn, addr, 16'h0);
        while (bus.rsp_valid !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        chk({name, " data"}, 32'(bus.rsp_rdata), 32'(exp));
        chk({name, " latency"}, 32'(n), 32'(lat));
    endtask

    task automatic wr(input string name, input logic size, input logic [7:0] addr,
                      input logic [15:0] wd, input int lat);
        int n = 1;
        issue(1'b1, size, 1'b0, addr, wd);
        if (lat == 2) chk({name, " ready low"}, 32'(bus.req_ready), 32'd0);
        while (bus.rsp_valid !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        chk({name, " wr rdata"}, 32'(bus.rsp_rdata), 32'd0);
        chk({name, " latency"}, 32'(n), 32'(lat));
    endtask

    task automatic op32(input string name, input logic we, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp);
        int n = 1;
        bus32.req_valid = 1'b1; bus32.req_we = we; bus32.req_size = 1'b1;
        bus32.req_signed = 1'b0; bus32.req_addr = addr; bus32.req_wdata = wd;
        @(negedge clk);
        bus32.req_valid = 1'b0; bus32.req_we = 1'b0;
        while (bus32.rsp_valid !== 1'b1 && n < 6) begin @(negedge clk); n++; end
        chk({name, " data"}, bus32.rsp_rdata, exp);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 1'b0; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0;
        bus32.req_valid = 1'b0; bus32.req_we = 1'b0; bus32.req_size = 1'b0; bus32.req_signed = 1'b0;
        bus32.req_addr = '0; bus32.req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(bus.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("reset cnt", 32'(bus.misalign_cnt), 32'd0);
        chk("reset32 ready", 32'(bus32.req_ready), 32'd1);
        rst = 1'b0;
        check_en = 1'b1;

        wr("aligned wr", 1'b1, 8'h10, 16'hABCD, 1);
        rd("aligned rd", 1'b1, 1'b0, 8'h10, 16'hABCD, 1);
        rd("byte 0x10", 1'b0, 1'b0, 8'h10, 16'h00AB, 1);
        rd("byte 0x11", 1'b0, 1'b0, 8'h11, 16'h00CD, 1);

        wr("byte wr 0x21", 1'b0, 8'h21, 16'h0080, 1);
        rd("signed byte", 1'b0, 1'b1, 8'h21, 16'hFF80, 1);
        rd("unsigned byte", 1'b0, 1'b0, 8'h21, 16'h0080, 1);

        wr("misaligned wr", 1'b1, 8'h31, 16'h1234, 2);
        rd("word 0x30", 1'b1, 1'b0, 8'h30, 16'h0012, 1);
        rd("word 0x32", 1'b1, 1'b0, 8'h32, 16'h3400, 1);
        rd("word 0x31", 1'b1, 1'b0, 8'h31, 16'h1234, 2);
        chk("misalign count", 32'(bus.misalign_cnt), 32'd2);

        wr("wrap wr", 1'b1, 8'hFF, 16'hBEEF, 2);
        rd("wrap byte 0xFF", 1'b0, 1'b0, 8'hFF, 16'h00BE, 1);
        rd("wrap byte 0x00", 1'b0, 1'b0, 8'h00, 16'h00EF, 1);
        rd("wrap word", 1'b1, 1'b0, 8'hFF, 16'hBEEF, 2);

        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 1'b1;
        bus.req_addr = 8'h41; bus.req_wdata = 16'h5566;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_we = 1'b0;
        chk("beat2 ready low", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst beat2 no rsp", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        chk("rst beat2 ready", 32'(bus.req_ready), 32'd1);
        chk("rst beat2 cnt", 32'(bus.misalign_cnt), 32'd0);
        rd("kept beat1", 1'b0, 1'b0, 8'h41, 16'h0055, 1);
        rd("dropped beat2", 1'b0, 1'b0, 8'h42, 16'h0000, 1);

        op32("w32 0x06", 1'b1, 8'h06, 32'h11223344, 32'h0);
        op32("w32 rd 0x04", 1'b0, 8'h04, 32'h0, 32'h00001122);
        op32("w32 rd 0x08", 1'b0, 8'h08, 32'h0, 32'h33440000);
        op32("w32 rd 0x06", 1'b0, 8'h06, 32'h0, 32'h11223344);

        for (int c = 0; c < 3000; c++) begin
            bus.req_valid  = ($urandom_range(0, 3) != 0);
            bus.req_we     = 1'($urandom_range(0, 1));
            bus.req_size   = 1'($urandom_range(0, 1));
            bus.req_signed = 1'($urandom_range(0, 1));
            bus.req_addr   = 8'(32'hF8 + $urandom_range(0, 15));
            bus.req_wdata  = 16'($urandom);
            rst            = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, byte-addressed, big-endian data memory with a valid/ready request port and a registered response port. It replaces the fixed 16-bit, 256-byte data memory in the single-cycle datapath's MEM stage. It adds configurable width and depth, byte and word access with optional sign extension, and misaligned word access split into two beats. It also provides address wrap-around and a misaligned-access counter.

## Interface
Parameters:
- DATA_W, 16, word width in bits; multiple of 8, >= 16; NB = DATA_W/8 bytes per word
- ADDR_W, 8, byte-address width; capacity 2**ADDR_W bytes, stored as 2**ADDR_W/NB rows of NB bytes

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; transfer when req_valid && req_ready at rising edge
- req_we  in  1  1 = write, 0 = read
- req_size  in  1  0 = byte, 1 = word
- req_signed  in  1  byte reads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data; byte writes use [7:0]
- rsp_valid  out  1  one-cycle pulse per completed request (reads and writes)
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes
- misalign_cnt  out  16  accepted misaligned word requests, saturating

## Operation
- Byte order is big-endian. Word at address a consists of bytes a+k mod 2**ADDR_W for k = 0..NB-1, with byte k on bits [DATA_W-1-8k -: 8].
- Row = addr / NB, lane = addr % NB. Lane 0 is the MSB byte of the row.
- Storage is one row-wide array with per-lane write enables. Only one row is accessed per cycle.
- Byte access or aligned word access (lane 0): single beat.
- Misaligned word access (lane != 0): two beats.
  - Beat 1 covers row r, lanes lane..NB-1.
  - Beat 2 covers row (r+1) mod rows, lanes 0..lane-1.
- Address wrap: the last row's successor is row 0. No error is raised.
- Byte read result is placed in rsp_rdata[7:0]. Upper bits are zero, or copies of bit 7 if req_signed.
- Memory contents are not affected by rst. They initialise to all zero at power-up.
- Two-state FSM:
  - IDLE: req_ready = 1. An accepted single-beat request completes at the accept edge and stays in IDLE. An accepted misaligned word executes beat 1 at the accept edge, latches the request, and goes to BEAT2.
  - BEAT2: req_ready = 0; req_valid is ignored. The next edge executes beat 2 and returns to IDLE.
- Reads assemble both beats into a holding register before presenting rsp_rdata.
- misalign_cnt increments at acceptance of a misaligned word and holds at 0xFFFF.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, misalign_cnt = 0, FSM = IDLE.
- Single-beat latency: rsp_valid is high the cycle after the accept edge. Writes are visible to a read accepted on the very next edge.
- Misaligned latency: rsp_valid is high 2 cycles after the accept edge, and req_ready is low for exactly 1 cycle.
- Throughput: single-beat requests sustain one per cycle with req_valid held high, giving one rsp_valid per cycle.
- rsp_valid is a pulse. There is no back-pressure on the response side.
- rst during BEAT2:
  - The beat-1 write is already committed and remains.
  - Beat 2 is dropped and no rsp_valid is produced.
  - The FSM returns to IDLE.
- rst has priority over an accept in the same cycle; the request is not executed.
- rsp_rdata holds its last value between pulses, except that reset clears it.

## Test plan
(DATA_W=16, ADDR_W=8 unless noted)
- Aligned write/read: write word 0xABCD @0x10, then read word @0x10. Expect 0xABCD with rsp one cycle after accept. Byte read @0x10 gives 0x00AB; byte read @0x11 gives 0x00CD.
- Sign extension: write byte 0x80 @0x21. Signed byte read gives 0xFF80; unsigned byte read gives 0x0080.
- Misaligned: write word 0x1234 @0x31. Expect req_ready low for 1 cycle and rsp 2 cycles after accept. Then:
  - read word @0x30 gives 0x0012;
  - read word @0x32 gives 0x3400;
  - read word @0x31 gives 0x1234;
  - misalign_cnt = 2.
- Wrap: write word 0xBEEF @0xFF. Byte @0xFF gives 0xBE; byte @0x00 gives 0xEF. Read word @0xFF gives 0xBEEF.
- Reset in BEAT2: write word 0x5566 @0x41, assert rst in the BEAT2 cycle. Expect:
  - no rsp_valid;
  - after reset, req_ready = 1 and misalign_cnt = 0;
  - byte @0x41 = 0x55, byte @0x42 = 0x00.
- DATA_W=32: write 0x11223344 @0x06. Read word @0x04 gives 0x00001122; read word @0x08 gives 0x33440000.
